cmd_cfg_mc: RTL

Parametrised successor to the logic-analyzer command/config block. It decodes 16-bit host commands, owns the capture configuration register file for NUM_CH channels, and answers register reads and writes with data or ACK/NAK. It streams captured samples from any channel's RAMqueue back through the UART response path. New over the fixed 5-channel version: channel count, depth, and sample width are generic; dump length is programmable (the last N samples); dumps are gated on capture_done; bad channels and bad addresses get a NAK.

---
 rtl/cmd_cfg_pkg.sv | 47 ++++
 rtl/cfg_regfile.sv | 136 +++++++++++++
 rtl/cmd_cfg_mc.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/cmd_cfg_pkg.sv
// Shared types and constants for the logic-analyzer command/config block:
// opcodes, FSM states, register addresses, response codes and reset values.
package cmd_cfg_pkg;

    typedef enum logic [1:0] {
        OP_RD   = 2'b00,
        OP_WR   = 2'b01,
        OP_DUMP = 2'b10,
        OP_RSVD = 2'b11
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_RESP,
        S_DUMP_RD,
        S_DUMP_TX,
        S_DUMP_WAIT
    } state_e;

    localparam logic [5:0] A_TRIG_CFG = 6'h00;
    localparam logic [5:0] A_DECIM    = 6'h10;
    localparam logic [5:0] A_VIH      = 6'h11;
    localparam logic [5:0] A_VIL      = 6'h12;
    localparam logic [5:0] A_MATCH_H  = 6'h13;
    localparam logic [5:0] A_MATCH_L  = 6'h14;
    localparam logic [5:0] A_MASK_H   = 6'h15;
    localparam logic [5:0] A_MASK_L   = 6'h16;
    localparam logic [5:0] A_BAUD_H   = 6'h17;
    localparam logic [5:0] A_BAUD_L   = 6'h18;
    localparam logic [5:0] A_TPOS_H   = 6'h19;
    localparam logic [5:0] A_TPOS_L   = 6'h1A;
    localparam logic [5:0] A_DLEN_H   = 6'h1B;
    localparam logic [5:0] A_DLEN_L   = 6'h1C;

    localparam logic [7:0] ACK = 8'hA5;
    localparam logic [7:0] NAK = 8'hEE;

    localparam logic [5:0]  RST_TRIG_CFG = 6'h03;
    localparam logic [4:0]  RST_CH_CFG   = 5'h01;
    localparam logic [3:0]  RST_DECIM    = 4'h0;
    localparam logic [7:0]  RST_VIH      = 8'hAA;
    localparam logic [7:0]  RST_VIL      = 8'h55;
    localparam logic [15:0] RST_BAUD     = 16'h06C8;
    localparam int unsigned RST_TRIG_POS = 1;

endpackage

// File: rtl/cfg_regfile.sv
// Capture configuration register file: storage, write decode, read mux and
// the capture_done flag (TrigCfg bit 5). Channel 1 occupies the lowest slice.
module cfg_regfile
    import cmd_cfg_pkg::*;
#(
    parameter int NUM_CH = 5,
    parameter int LOG2   = 9
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [5:0]          addr,
    input  logic [7:0]          wdata,
    input  logic                set_capture_done,
    input  logic                clr_capture_done,
    output logic [7:0]          rd_data,
    output logic                addr_valid,
    output logic                capture_done,
    output logic [5:0]          trig_cfg,
    output logic [NUM_CH*5-1:0] ch_trig_cfg,
    output logic [3:0]          decimator,
    output logic [7:0]          vih,
    output logic [7:0]          vil,
    output logic [15:0]         match,
    output logic [15:0]         mask,
    output logic [15:0]         baud_cnt,
    output logic [LOG2-1:0]     trig_pos,
    output logic [LOG2:0]       dump_len
);

    localparam int DLW = LOG2 + 1;

    logic [5:0]             trig_cfg_q;
    logic [NUM_CH-1:0][4:0] ch_cfg_q;
    logic [3:0]             decim_q;
    logic [7:0]             vih_q, vil_q;
    logic [15:0]            match_q, mask_q, baud_q;
    logic [LOG2-1:0]        tpos_q;
    logic [DLW-1:0]         dlen_q;

    // 16-bit views let the H/L byte writes and reads work for any LOG2.
    logic [15:0] tpos_w, dlen_w;
    logic        is_ch;

    assign tpos_w = 16'(tpos_q);
    assign dlen_w = 16'(dlen_q);
    assign is_ch  = (int'(addr) >= 1) && (int'(addr) <= NUM_CH);

    assign addr_valid = (addr == A_TRIG_CFG) || is_ch ||
                        ((addr >= A_DECIM) && (addr <= A_DLEN_L));

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            trig_cfg_q <= RST_TRIG_CFG;
            for (int k = 0; k < NUM_CH; k++) ch_cfg_q[k] <= RST_CH_CFG;
            decim_q    <= RST_DECIM;
            vih_q      <= RST_VIH;
            vil_q      <= RST_VIL;
            match_q    <= '0;
            mask_q     <= '0;
            baud_q     <= RST_BAUD;
            tpos_q     <= LOG2'(RST_TRIG_POS);
            dlen_q     <= '0;
        end else begin
            if (wr_en) begin
                case (addr)
                    A_TRIG_CFG: trig_cfg_q[4:0] <= wdata[4:0];
                    A_DECIM:    decim_q         <= wdata[3:0];
                    A_VIH:      vih_q           <= wdata;
                    A_VIL:      vil_q           <= wdata;
                    A_MATCH_H:  match_q[15:8]   <= wdata;
                    A_MATCH_L:  match_q[7:0]    <= wdata;
                    A_MASK_H:   mask_q[15:8]    <= wdata;
                    A_MASK_L:   mask_q[7:0]     <= wdata;
                    A_BAUD_H:   baud_q[15:8]    <= wdata;
                    A_BAUD_L:   baud_q[7:0]     <= wdata;
                    A_TPOS_H:   tpos_q          <= LOG2'({wdata, tpos_w[7:0]});
                    A_TPOS_L:   tpos_q          <= LOG2'({tpos_w[15:8], wdata});
                    A_DLEN_H:   dlen_q          <= DLW'({wdata, dlen_w[7:0]});
                    A_DLEN_L:   dlen_q          <= DLW'({dlen_w[15:8], wdata});
                    default: ;
                endcase
                for (int k = 0; k < NUM_CH; k++) begin
                    if (int'(addr) == k + 1) ch_cfg_q[k] <= wdata[4:0];
                end
            end

            // capture_done priority: hardware set, then host write, then dump clear.
            if (set_capture_done)
                trig_cfg_q[5] <= 1'b1;
            else if (wr_en && (addr == A_TRIG_CFG))
                trig_cfg_q[5] <= wdata[5];
            else if (clr_capture_done)
                trig_cfg_q[5] <= 1'b0;
        end
    end

    always_comb begin
        // NOTE: default assigned first so no latch is inferred on unmapped addresses.
        rd_data = '0;
        case (addr)
            A_TRIG_CFG: rd_data = {2'b00, trig_cfg_q};
            A_DECIM:    rd_data = {4'h0, decim_q};
            A_VIH:      rd_data = vih_q;
            A_VIL:      rd_data = vil_q;
            A_MATCH_H:  rd_data = match_q[15:8];
            A_MATCH_L:  rd_data = match_q[7:0];
            A_MASK_H:   rd_data = mask_q[15:8];
            A_MASK_L:   rd_data = mask_q[7:0];
            A_BAUD_H:   rd_data = baud_q[15:8];
            A_BAUD_L:   rd_data = baud_q[7:0];
            A_TPOS_H:   rd_data = tpos_w[15:8];
            A_TPOS_L:   rd_data = tpos_w[7:0];
            A_DLEN_H:   rd_data = dlen_w[15:8];
            A_DLEN_L:   rd_data = dlen_w[7:0];
            default: ;
        endcase
        for (int k = 0; k < NUM_CH; k++) begin
            if (int'(addr) == k + 1) rd_data = {3'b000, ch_cfg_q[k]};
        end
    end

    assign capture_done = trig_cfg_q[5];
    assign trig_cfg     = trig_cfg_q;
    assign ch_trig_cfg  = ch_cfg_q;
    assign decimator    = decim_q;
    assign vih          = vih_q;
    assign vil          = vil_q;
    assign match        = match_q;
    assign mask         = mask_q;
    assign baud_cnt     = baud_q;
    assign trig_pos     = tpos_q;
    assign dump_len     = dlen_q;

endmodule

// File: rtl/cmd_cfg_mc.sv
// Command decoder and dump sequencer: answers RD/WR with data or ACK/NAK and
// streams the most recent dump_len samples of one channel, oldest first.
module cmd_cfg_mc
    import cmd_cfg_pkg::*;
#(
    parameter int NUM_CH  = 5,
    parameter int ENTRIES = 384,
    parameter int LOG2    = 9,
    parameter int DATA_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [15:0]              cmd,
    input  logic                     cmd_rdy,
    input  logic                     resp_sent,
    input  logic                     set_capture_done,
    input  logic [LOG2-1:0]          waddr,
    input  logic [NUM_CH*DATA_W-1:0] rdata,
    output logic [LOG2-1:0]          raddr,
    output logic [7:0]               resp,
    output logic                     send_resp,
    output logic                     clr_cmd_rdy,
    output logic [LOG2-1:0]          trig_pos,
    output logic [5:0]               TrigCfg,
    output logic [NUM_CH*5-1:0]      ch_trig_cfg,
    output logic [3:0]               decimator,
    output logic [7:0]               VIH,
    output logic [7:0]               VIL,
    output logic [15:0]              match,
    output logic [15:0]              mask,
    output logic [15:0]              baud_cnt
);

    localparam int CW = LOG2 + 1;
    localparam int SW = LOG2 + 2;
    localparam logic [CW-1:0] ENTRIES_C = CW'(ENTRIES);

    state_e          state_q, state_d;
    logic [LOG2-1:0] raddr_q, raddr_d;
    logic [7:0]      resp_q, resp_d;
    logic            send_q, send_d;
    logic            clr_q, clr_d;
    logic [CW-1:0]   remain_q, remain_d;
    logic [2:0]      chan_q, chan_d;

    opcode_e         opcode;
    logic [5:0]      addr;
    logic [2:0]      dump_ch;
    logic            wr_en, clr_capture;
    logic [7:0]      rd_data;
    logic            addr_valid, capture_done, dump_ok;
    logic [CW-1:0]   dump_len, dump_cnt;
    logic [SW-1:0]   start_sum;
    logic [LOG2-1:0] start_addr, raddr_inc;
    logic [DATA_W-1:0] sample;

    assign opcode  = opcode_e'(cmd[15:14]);
    assign addr    = cmd[13:8];
    assign dump_ch = cmd[10:8] | cmd[13:11];
    assign dump_ok = (dump_ch != 3'd0) && (int'(dump_ch) <= NUM_CH) && capture_done;

    cfg_regfile #(
        .NUM_CH (NUM_CH),
        .LOG2   (LOG2)
    ) u_regfile (
        .clk              (clk),
        .rst_n            (rst_n),
        .wr_en            (wr_en),
        .addr             (addr),
        .wdata            (cmd[7:0]),
        .set_capture_done (set_capture_done),
        .clr_capture_done (clr_capture),
        .rd_data          (rd_data),
        .addr_valid       (addr_valid),
        .capture_done     (capture_done),
        .trig_cfg         (TrigCfg),
        .ch_trig_cfg      (ch_trig_cfg),
        .decimator        (decimator),
        .vih              (VIH),
        .vil              (VIL),
        .match            (match),
        .mask             (mask),
        .baud_cnt         (baud_cnt),
        .trig_pos         (trig_pos),
        .dump_len         (dump_len)
    );

    // Zero or oversized dump_len means the whole queue; the start address
    // walks back L entries from the oldest-sample pointer, modulo depth.
    assign dump_cnt   = ((dump_len == '0) || (dump_len > ENTRIES_C)) ? ENTRIES_C : dump_len;
    assign start_sum  = SW'(waddr) + SW'(ENTRIES) - SW'(dump_cnt);
    assign start_addr = (start_sum >= SW'(ENTRIES)) ? LOG2'(start_sum - SW'(ENTRIES))
                                                     : LOG2'(start_sum);
    assign raddr_inc  = (raddr_q == LOG2'(ENTRIES - 1)) ? '0 : raddr_q + 1'b1;

    always_comb begin
        sample = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (int'(chan_q) == k + 1) sample = rdata[k*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            raddr_q  <= '0;
            resp_q   <= '0;
            send_q   <= 1'b0;
            clr_q    <= 1'b0;
            remain_q <= '0;
            chan_q   <= '0;
        end else begin
            state_q  <= state_d;
            raddr_q  <= raddr_d;
            resp_q   <= resp_d;
            send_q   <= send_d;
            clr_q    <= clr_d;
            remain_q <= remain_d;
            chan_q   <= chan_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        raddr_d     = raddr_q;
        resp_d      = resp_q;
        send_d      = 1'b0;
        clr_d       = 1'b0;
        remain_d    = remain_q;
        chan_d      = chan_q;
        wr_en       = 1'b0;
        clr_capture = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_rdy) state_d = S_DECODE;
            end

            S_DECODE: begin
                send_d  = 1'b1;
                clr_d   = 1'b1;
                resp_d  = NAK;
                state_d = S_RESP;
                case (opcode)
                    OP_RD: if (addr_valid) resp_d = rd_data;
                    OP_WR: begin
                        wr_en = addr_valid;
                        if (addr_valid) resp_d = ACK;
                    end
                    OP_DUMP: begin
                        if (dump_ok) begin
                            send_d   = 1'b0;
                            clr_d    = 1'b0;
                            resp_d   = resp_q;
                            chan_d   = dump_ch;
                            raddr_d  = start_addr;
                            remain_d = dump_cnt;
                            state_d  = S_DUMP_RD;
                        end
                    end
                    default: ;
                endcase
            end

            S_RESP: state_d = S_IDLE;

            S_DUMP_RD: state_d = S_DUMP_TX;

            S_DUMP_TX: begin
                resp_d  = 8'(sample);
                send_d  = 1'b1;
                state_d = S_DUMP_WAIT;
                if (remain_q == CW'(1)) begin
                    clr_d       = 1'b1;
                    clr_capture = 1'b1;
                end
            end

            S_DUMP_WAIT: begin
                if (resp_sent) begin
                    if (remain_q == CW'(1)) begin
                        state_d = S_IDLE;
                    end else begin
                        raddr_d  = raddr_inc;
                        remain_d = remain_q - 1'b1;
                        state_d  = S_DUMP_RD;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    assign raddr       = raddr_q;
    assign resp        = resp_q;
    assign send_resp   = send_q;
    assign clr_cmd_rdy = clr_q;

endmodule
